or_atom_engine: RTL and testbench
=================================

OR_ATOM_ENGINE -- requirements
Module: or_atom_engine

Interface
REQ-001 Parameter DATA_W, default 8, width of data words, result and readdata.
REQ-002 Parameter ADDR_W, default 8, width of word addresses.
REQ-003 Parameter LEN_W, default 8, width of the length input and word counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  start/run level from control register block; high = run requested.
REQ-007 base_addr  input  ADDR_W  first word address, sampled on start.
REQ-008 length  input  LEN_W  number of words to reduce, sampled on start.
REQ-009 done  output  1  completion level, held until en deasserts.
REQ-010 busy  output  1  high in REQ or WAIT state.
REQ-011 result  output  DATA_W  bitwise-OR of all words read, stable while done=1.
REQ-012 avm_address  output  ADDR_W  Avalon-MM master word address.
REQ-013 avm_read  output  1  Avalon-MM read request.
REQ-014 avm_readdata  input  DATA_W  Avalon-MM read data.
REQ-015 avm_waitrequest  input  1  slave stall; request accepted in a cycle where avm_read=1 and avm_waitrequest=0.
REQ-016 avm_readdatavalid  input  1  avm_readdata valid this cycle.

Function
REQ-017 Block SHALL implement states IDLE, REQ, WAIT, DONE, encoded in one state register.
REQ-018 IDLE: when en=1, SHALL latch base_addr into an address register, latch length into a remaining counter, clear accumulator, and go to REQ, or go to DONE if length=0.
REQ-019 REQ: avm_read SHALL be 1 and avm_address SHALL equal the address register; both SHALL stay stable while avm_waitrequest=1.
REQ-020 On acceptance in REQ, SHALL increment address (mod 2^ADDR_W, wrap permitted) and go to WAIT.
REQ-021 WAIT: avm_read SHALL be 0; at most one read SHALL be outstanding.
REQ-022 In WAIT with avm_readdatavalid=1, accumulator SHALL become accumulator OR avm_readdata and remaining SHALL decrement.
REQ-023 After that update, SHALL go to DONE if remaining was 1, else to REQ (next request no earlier than the following cycle).
REQ-024 avm_readdatavalid outside WAIT SHALL be ignored.
REQ-025 DONE: done=1 and result=accumulator; SHALL stay in DONE while en=1; on en=0 SHALL go to IDLE with done=0 the next cycle.
REQ-026 result SHALL hold its last value in IDLE and update only on entry to DONE.
REQ-027 Abort: en=0 in REQ SHALL return to IDLE only in a cycle where avm_read is not stalled (avm_waitrequest=0 and request accepted, or before issue); a stalled request SHALL be held until accepted.
REQ-028 Abort in WAIT SHALL wait for the outstanding avm_readdatavalid, discard it, then go to IDLE; done SHALL NOT assert on abort.
REQ-029 Per-word throughput SHALL be at most one word per 2 cycles with zero wait states and one-cycle read latency.

Reset
REQ-030 reset_n=0 SHALL force state IDLE, done=0, busy=0, avm_read=0, avm_address=0, result=0, accumulator=0, counter=0 immediately, independent of clk.
REQ-031 Reset mid-transfer SHALL abandon any outstanding read; later avm_readdatavalid SHALL be ignored per REQ-024.

Verification
REQ-032 base_addr=0x10, length=3, memory 0x01,0x02,0x80, no wait states, en=1 -> reads 0x10,0x11,0x12; done=1 with result=0x83.
REQ-033 length=0, en=1 -> no avm_read; done=1 one cycle later with result=0x00.
REQ-034 waitrequest held 3 cycles on first read -> avm_read and avm_address=0x10 stable over all 3 stall cycles; final result unchanged.
REQ-035 base_addr=0xFF, length=2 -> addresses 0xFF then 0x00 (wrap).
REQ-036 en dropped in WAIT of word 2 of 4 -> readdatavalid consumed, IDLE next cycle, done never 1, result keeps previous value.
REQ-037 reset_n pulsed low in REQ -> avm_read=0 and state IDLE asynchronously; a new en=1 runs a full correct reduction.

Source files
------------

// File: rtl/or_atom_engine.sv
// Avalon-MM read master that reduces a block of words with bitwise OR.
// Issues one read at a time, walks the address range, and reports the result on done.
module or_atom_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining;
    logic [DATA_W-1:0]  acc;
    logic               accepted;
    logic [DATA_W-1:0]  acc_next;

    function automatic logic [DATA_W-1:0] or_merge(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a | b;
    endfunction

    function automatic logic last_word(input logic [LEN_W-1:0] cnt);
        return cnt == LEN_W'(1);
    endfunction

    // The address register drives the bus directly, so it is stable during stalls.
    assign avm_address = addr;
    assign accepted    = avm_read && !avm_waitrequest;
    assign acc_next    = or_merge(acc, avm_readdata);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            acc       <= '0;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            avm_read  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        addr      <= base_addr;
                        remaining <= length;
                        acc       <= '0;
                        if (length == '0) begin
                            state  <= DONE;
                            result <= '0;
                            done   <= 1'b1;
                        end else begin
                            state    <= REQ;
                            busy     <= 1'b1;
                            avm_read <= 1'b1;
                        end
                    end
                end

                // A stalled request is never withdrawn; abort only once it is accepted.
                REQ: begin
                    if (accepted) begin
                        addr     <= addr + ADDR_W'(1);
                        avm_read <= 1'b0;
                        if (en) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end

                WAIT: begin
                    if (avm_readdatavalid) begin
                        if (!en) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            acc       <= acc_next;
                            remaining <= remaining - LEN_W'(1);
                            if (last_word(remaining)) begin
                                state  <= DONE;
                                result <= acc_next;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                            end else begin
                                state    <= REQ;
                                avm_read <= 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    if (!en) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or_atom_engine.sv
// Directed bench for or_atom_engine with a simple Avalon-MM slave memory model.
module tb_or_atom_engine;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [7:0] base_addr;
    logic [7:0] length;
    logic       done;
    logic       busy;
    logic [7:0] result;
    logic [7:0] avm_address;
    logic       avm_read;
    logic [7:0] avm_readdata;
    logic       avm_waitrequest;
    logic       avm_readdatavalid;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [256];
    logic [7:0] addr_log [$];
    int         stall_left = 0;
    int         rd_cycles = 0;
    logic       acc_pend = 1'b0;
    logic [7:0] acc_addr = 8'h00;
    int         cyc;

    or_atom_engine #(.DATA_W(8), .ADDR_W(8), .LEN_W(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .en               (en),
        .base_addr        (base_addr),
        .length           (length),
        .done             (done),
        .busy             (busy),
        .result           (result),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_readdata     (avm_readdata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdatavalid(avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave: one-cycle read latency, optional stall count on the next request.
    always @(negedge clk) begin
        if (acc_pend) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem[acc_addr];
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 8'hA5;
        end
        if (avm_read && stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left      = stall_left - 1;
        end else begin
            avm_waitrequest = 1'b0;
        end
        acc_pend = avm_read && !avm_waitrequest;
        if (acc_pend) begin
            acc_addr = avm_address;
            addr_log.push_back(avm_address);
        end
        if (avm_read) rd_cycles = rd_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 200) begin
            tick();
            cycles++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic start(input logic [7:0] b, input logic [7:0] l);
        addr_log.delete();
        rd_cycles = 0;
        base_addr = b;
        length    = l;
        en        = 1'b1;
    endtask

    task automatic stop_run();
        en = 1'b0;
        tick();
        check("done_clears", {31'd0, done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h80;
        mem[8'hFF] = 8'h0C; mem[8'h00] = 8'h30;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h02; mem[8'h22] = 8'h04; mem[8'h23] = 8'h08;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 8'h00;
        en        = 1'b0;
        base_addr = 8'h00;
        length    = 8'h00;
        reset_n   = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_addr", {24'd0, avm_address}, 32'h00);
        check("rst_result", {24'd0, result}, 32'h00);
        reset_n = 1'b1;
        tick();

        // Basic three-word reduction
        start(8'h10, 8'd3);
        wait_done(cyc);
        check("basic_cycles", cyc, 7);
        check("basic_result", {24'd0, result}, 32'h83);
        check("basic_busy", {31'd0, busy}, 32'd0);
        check("basic_nreads", addr_log.size(), 3);
        if (addr_log.size() == 3) begin
            check("basic_a0", {24'd0, addr_log[0]}, 32'h10);
            check("basic_a1", {24'd0, addr_log[1]}, 32'h11);
            check("basic_a2", {24'd0, addr_log[2]}, 32'h12);
        end
        tick();
        tick();
        check("done_held", {31'd0, done}, 32'd1);
        stop_run();
        check("result_kept_idle", {24'd0, result}, 32'h83);

        // Zero length
        start(8'h40, 8'd0);
        tick();
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_result", {24'd0, result}, 32'h00);
        check("zero_busy", {31'd0, busy}, 32'd0);
        tick();
        check("zero_no_read", rd_cycles, 0);
        stop_run();

        // Three-cycle stall on the first request
        stall_left = 3;
        start(8'h10, 8'd3);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("stall_read", {31'd0, avm_read}, 32'd1);
            check("stall_addr", {24'd0, avm_address}, 32'h10);
            tick();
        end
        wait_done(cyc);
        check("stall_result", {24'd0, result}, 32'h83);
        check("stall_nreads", addr_log.size(), 3);
        stop_run();

        // Address wrap
        start(8'hFF, 8'd2);
        wait_done(cyc);
        check("wrap_result", {24'd0, result}, 32'h3C);
        check("wrap_nreads", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("wrap_a0", {24'd0, addr_log[0]}, 32'hFF);
            check("wrap_a1", {24'd0, addr_log[1]}, 32'h00);
        end
        stop_run();

        // Abort in WAIT of word 2 of 4
        start(8'h20, 8'd4);
        tick();
        tick();
        tick();
        tick();
        check("abort_in_wait_read", {31'd0, avm_read}, 32'd0);
        check("abort_in_wait_busy", {31'd0, busy}, 32'd1);
        en = 1'b0;
        tick();
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        check("abort_idle_read", {31'd0, avm_read}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("abort_no_done", {31'd0, done}, 32'd0);
            check("abort_result", {24'd0, result}, 32'h3C);
            tick();
        end
        check("abort_nreads", addr_log.size(), 2);

        // Asynchronous reset while in REQ
        start(8'h10, 8'd3);
        tick();
        check("rstreq_read_before", {31'd0, avm_read}, 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rstreq_read", {31'd0, avm_read}, 32'd0);
        check("rstreq_busy", {31'd0, busy}, 32'd0);
        check("rstreq_result", {24'd0, result}, 32'h00);
        en = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start(8'h10, 8'd3);
        wait_done(cyc);
        check("after_rst_cycles", cyc, 7);
        check("after_rst_result", {24'd0, result}, 32'h83);
        stop_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
